// File: rtl/cv32e40p_alu_tmr_fault_ctrl.sv
// Fault manager for the triplicated ALU: leaky per-replica error counters,
// sticky faulty flags, replay sequencing on no-majority votes and fatal escalation.
module cv32e40p_alu_tmr_fault_ctrl #(
  parameter int CNT_W        = 4,
  parameter int ERR_THRESH   = 8,
  parameter int DECAY_PERIOD = 1024,
  parameter int MAX_RETRY    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid_i,
  input  logic [2:0]         mism_i,
  input  logic               nomaj_i,
  input  logic               clear_i,
  output logic               retry_o,
  output logic               stall_o,
  output logic [2:0]         faulty_o,
  output logic [3*CNT_W-1:0] err_cnt_o,
  output logic               corr_evt_o,
  output logic               fatal_o
);

  typedef enum logic [1:0] {ST_RUN, ST_RETRY, ST_FATAL} state_e;

  localparam int TMR_W = (DECAY_PERIOD > 2) ? $clog2(DECAY_PERIOD) : 1;
  localparam int RC_W  = $clog2(MAX_RETRY + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] THRESH_V = CNT_W'(ERR_THRESH);
  localparam logic [TMR_W-1:0] WRAP_V   = TMR_W'(DECAY_PERIOD - 1);
  localparam logic [RC_W-1:0]  RC_MAX   = RC_W'(MAX_RETRY);

  state_e           r_state;
  logic [TMR_W-1:0] r_timer;
  logic [RC_W-1:0]  r_rcnt;
  logic [CNT_W-1:0] r_cnt [3];
  logic [2:0]       r_faulty;
  logic             r_retry;
  logic             r_stall;
  logic             r_corr;
  logic             r_fatal;

  logic [2:0]       w_masked;
  logic [1:0]       w_nm;
  logic [1:0]       w_nf;
  logic             w_nomaj;
  logic             w_single;
  logic             w_wrap;
  logic [CNT_W-1:0] w_cnt_nxt [3];
  logic [2:0]       w_faulty_nxt;

  // Faulty replicas no longer take part in the vote, so their mismatches are ignored.
  assign w_masked = mism_i & ~r_faulty;
  assign w_nm     = 2'(w_masked[0]) + 2'(w_masked[1]) + 2'(w_masked[2]);
  assign w_nf     = 2'(r_faulty[0]) + 2'(r_faulty[1]) + 2'(r_faulty[2]);
  assign w_nomaj  = op_valid_i & (nomaj_i | (w_nm >= 2'd2) | ((w_nf == 2'd1) & (w_nm != 2'd0)));
  assign w_single = op_valid_i & ~nomaj_i & (w_nm == 2'd1) & (w_nf == 2'd0);
  assign w_wrap   = (r_timer == WRAP_V);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_faulty_nxt = r_faulty;
    for (int k = 0; k < 3; k++) begin
      w_cnt_nxt[k] = r_cnt[k];
      if (w_single && w_masked[k]) begin
        // An increment on a wrap cycle takes precedence over the decay.
        if (r_cnt[k] != CNT_MAX) w_cnt_nxt[k] = r_cnt[k] + 1'b1;
        if (w_cnt_nxt[k] == THRESH_V) w_faulty_nxt[k] = 1'b1;
      end else if (w_wrap && !r_faulty[k] && (r_cnt[k] != '0)) begin
        w_cnt_nxt[k] = r_cnt[k] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    if (rst || clear_i) begin
      r_state  <= ST_RUN;
      r_timer  <= '0;
      r_rcnt   <= '0;
      r_cnt    <= '{default: '0};
      r_faulty <= '0;
      r_retry  <= 1'b0;
      r_stall  <= 1'b0;
      r_corr   <= 1'b0;
      r_fatal  <= 1'b0;
    end else begin
      r_retry <= 1'b0;
      r_corr  <= 1'b0;
      r_timer <= w_wrap ? '0 : r_timer + 1'b1;
      if (r_state != ST_FATAL) begin
        r_cnt    <= w_cnt_nxt;
        r_faulty <= w_faulty_nxt;
        r_corr   <= w_single;
        if (w_nf >= 2'd2) begin
          r_state <= ST_FATAL;
          r_stall <= 1'b1;
          r_fatal <= 1'b1;
        end else begin
          unique case (r_state)
            ST_RUN: begin
              if (w_nomaj) begin
                r_state <= ST_RETRY;
                r_rcnt  <= RC_W'(1);
                r_retry <= 1'b1;
                r_stall <= 1'b1;
              end
            end
            ST_RETRY: begin
              if (w_nomaj) begin
                if (r_rcnt == RC_MAX) begin
                  r_state <= ST_FATAL;
                  r_fatal <= 1'b1;
                end else begin
                  r_rcnt  <= r_rcnt + 1'b1;
                  r_retry <= 1'b1;
                end
              end else if (op_valid_i) begin
                r_state <= ST_RUN;
                r_rcnt  <= '0;
                r_stall <= 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign retry_o    = r_retry;
  assign stall_o    = r_stall;
  assign faulty_o   = r_faulty;
  assign err_cnt_o  = {r_cnt[2], r_cnt[1], r_cnt[0]};
  assign corr_evt_o = r_corr;
  assign fatal_o    = r_fatal;

endmodule
